// File: rtl/aes_128_sched.sv
// Round-robin scheduler that shares one AES-128 core among four requesters.
// Optional response watchdog is enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_128_sched (
    input  logic         clk,
    input  logic         kill,
    input  logic [3:0]   req,
    input  logic [511:0] req_data,
    output logic [3:0]   gnt,
    output logic         core_in_en,
    output logic [127:0] core_data_in,
    input  logic         core_out_en,
    input  logic [127:0] core_data_out,
    output logic [3:0]   res_valid,
    output logic [127:0] res_data,
    output logic         busy,
    output logic         core_kill,
    output logic         timeout_irq_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t       r_state;
    logic [1:0]   r_ptr;
    logic [1:0]   r_owner;
    logic [3:0]   r_gnt;
    logic         r_core_in_en;
    logic [127:0] r_core_data_in;
    logic [3:0]   r_res_valid;
    logic [127:0] r_res_data;
    logic         r_busy;
    logic [1:0]   w_winner;
    logic [127:0] w_slice;

    // NOTE: w_winner gets a default before the loop, so no latch can be inferred.
    always_comb begin
        w_winner = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) w_winner = r_ptr + 2'(k);
        end
    end

    assign w_slice = req_data[{w_winner, 7'd0} +: 128];

`ifdef AES_SCHED_TIMEOUT_EN
    logic [5:0] r_wdog;
    logic       r_core_kill;
    logic       r_timeout_irq;

    assign core_kill         = r_core_kill;
    assign timeout_irq_pulse = r_timeout_irq;
`else
    assign core_kill         = 1'b0;
    assign timeout_irq_pulse = 1'b0;
`endif

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            r_state        <= S_IDLE;
            r_ptr          <= 2'd0;
            r_owner        <= 2'd0;
            r_gnt          <= 4'd0;
            r_core_in_en   <= 1'b0;
            r_core_data_in <= 128'd0;
            r_res_valid    <= 4'd0;
            r_res_data     <= 128'd0;
            r_busy         <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
            r_wdog         <= 6'd0;
            r_core_kill    <= 1'b0;
            r_timeout_irq  <= 1'b0;
`endif
        end else begin
            r_gnt        <= 4'd0;
            r_core_in_en <= 1'b0;
            r_res_valid  <= 4'd0;
`ifdef AES_SCHED_TIMEOUT_EN
            r_core_kill   <= 1'b0;
            r_timeout_irq <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner        <= w_winner;
                        r_core_data_in <= w_slice;
                        r_gnt          <= 4'b0001 << w_winner;
                        r_core_in_en   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef AES_SCHED_TIMEOUT_EN
                    r_wdog  <= 6'd0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response arriving on the expiry cycle still wins.
                    if (core_out_en) begin
                        r_res_data  <= core_data_out;
                        r_res_valid <= 4'b0001 << r_owner;
                        r_state     <= S_DELIVER;
                    end
`ifdef AES_SCHED_TIMEOUT_EN
                    else if (r_wdog == 6'd63) begin
                        r_core_kill   <= 1'b1;
                        r_timeout_irq <= 1'b1;
                        r_ptr         <= r_owner + 2'd1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 6'd1;
                    end
`endif
                end
                S_DELIVER: begin
                    r_ptr   <= r_owner + 2'd1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign core_in_en   = r_core_in_en;
    assign core_data_in = r_core_data_in;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign busy         = r_busy;

endmodule

// File: tb/tb_aes_128_sched.sv
// Directed bench for aes_128_sched: transaction-level reference model plus literal checks.
// Watchdog scenarios run only when AES_SCHED_TIMEOUT_EN is defined.
module tb_aes_128_sched;

    localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D0    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] D1    = 128'h11111111222222223333333344444444;
    localparam logic [127:0] D2    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D3    = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] D2_CT = 128'h00102030405060708090a0b0c0d0e0f0;
`ifdef AES_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic         clk;
    logic         kill;
    logic [3:0]   req;
    logic [511:0] req_data;
    logic [3:0]   gnt;
    logic         core_in_en;
    logic [127:0] core_data_in;
    logic         core_out_en;
    logic [127:0] core_data_out;
    logic [3:0]   res_valid;
    logic [127:0] res_data;
    logic         busy;
    logic         core_kill;
    logic         timeout_irq_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    aes_128_sched dut (
        .clk               (clk),
        .kill              (kill),
        .req               (req),
        .req_data          (req_data),
        .gnt               (gnt),
        .core_in_en        (core_in_en),
        .core_data_in      (core_data_in),
        .core_out_en       (core_out_en),
        .core_data_out     (core_data_out),
        .res_valid         (res_valid),
        .res_data          (res_data),
        .busy              (busy),
        .core_kill         (core_kill),
        .timeout_irq_pulse (timeout_irq_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction phases (0 idle, 1 issued, 2 awaiting core, 3 delivering).
    int           m_phase, m_ptr, m_owner, m_wait;
    logic [3:0]   e_gnt, e_rv;
    logic         e_cin, e_busy, e_ck, e_tirq;
    logic [127:0] e_cdata, e_rdata;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    always @(posedge clk or posedge kill) begin
        if (kill) begin
            m_phase <= 0; m_ptr <= 0; m_owner <= 0; m_wait <= 0;
            e_gnt <= 4'd0; e_cin <= 1'b0; e_cdata <= 128'd0; e_rv <= 4'd0;
            e_rdata <= 128'd0; e_busy <= 1'b0; e_ck <= 1'b0; e_tirq <= 1'b0;
        end else begin
            e_gnt <= 4'd0; e_cin <= 1'b0; e_rv <= 4'd0; e_ck <= 1'b0; e_tirq <= 1'b0;
            case (m_phase)
                0: if (req != 4'd0) begin
                    m_owner <= rr_pick(req, m_ptr);
                    e_gnt   <= 4'(1 << rr_pick(req, m_ptr));
                    e_cin   <= 1'b1;
                    e_cdata <= req_data[rr_pick(req, m_ptr) * 128 +: 128];
                    e_busy  <= 1'b1;
                    m_phase <= 1;
                end
                1: begin
                    m_wait  <= 1;
                    m_phase <= 2;
                end
                2: if (core_out_en) begin
                    e_rv    <= 4'(1 << m_owner);
                    e_rdata <= core_data_out;
                    m_phase <= 3;
                end else if (TIMEOUT_EN && m_wait == 64) begin
                    e_ck    <= 1'b1;
                    e_tirq  <= 1'b1;
                    e_busy  <= 1'b0;
                    m_ptr   <= (m_owner + 1) % 4;
                    m_phase <= 0;
                end else begin
                    m_wait <= m_wait + 1;
                end
                default: begin
                    m_ptr   <= (m_owner + 1) % 4;
                    e_busy  <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("cyc_gnt", gnt, e_gnt);
        check("cyc_core_in_en", core_in_en, e_cin);
        check("cyc_core_data_in", core_data_in, e_cdata);
        check("cyc_res_valid", res_valid, e_rv);
        check("cyc_res_data", res_data, e_rdata);
        check("cyc_busy", busy, e_busy);
        check("cyc_core_kill", core_kill, e_ck);
        check("cyc_timeout_irq", timeout_irq_pulse, e_tirq);
    end

    task automatic wait_gnt(input logic [3:0] exp_gnt, input logic [127:0] exp_block);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'd0 && n < 20);
        check("gnt", gnt, exp_gnt);
        check("core_in_en", core_in_en, 1'b1);
        check("core_data_in", core_data_in, exp_block);
    endtask

    // Requester + core stimulus for one transaction; core answers on WAIT cycle lat.
    task automatic do_txn(input logic [3:0] exp_gnt, input logic [127:0] exp_block, input int lat,
                          input logic [3:0] req_on_gnt, input logic [3:0] req_in_wait,
                          input bit spur_issue);
        logic [127:0] blk;
        wait_gnt(exp_gnt, exp_block);
        blk = core_data_in;
        req = req_on_gnt;
        if (spur_issue) begin
            core_out_en   = 1'b1;
            core_data_out = ~KEY;
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            core_out_en = 1'b0;
            if (c == 1) begin
                req = req_in_wait;
                if (spur_issue) check("spur_issue_rv", res_valid, 4'd0);
            end
            if (c == lat) begin
                core_out_en   = 1'b1;
                core_data_out = blk ^ KEY;
            end
        end
        @(negedge clk);
        core_out_en = 1'b0;
        check("res_valid", res_valid, exp_gnt);
        check("res_data", res_data, exp_block ^ KEY);
    endtask

    initial begin
        logic [127:0] blk_tab [4];
        blk_tab = '{D0, D1, D2, D3};
        kill = 1'b1; req = 4'd0; req_data = {D3, D2, D1, D0};
        core_out_en = 1'b0; core_data_out = 128'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", gnt, 4'd0);
        check("rst_res_valid", res_valid, 4'd0);
        check("rst_core_data_in", core_data_in, 128'd0);
        kill = 1'b0;

        // Single requester 2, core latency 30.
        req = 4'b0100;
        do_txn(4'b0100, D2, 30, 4'd0, 4'd0, 1'b0);
        check("t1_res_literal", res_data, D2_CT);

        // Spurious core_out_en in IDLE, then in ISSUE.
        @(negedge clk);
        core_out_en = 1'b1; core_data_out = ~KEY;
        @(negedge clk);
        core_out_en = 1'b0;
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_rv", res_valid, 4'd0);
        check("spur_idle_hold", res_data, D2_CT);
        req = 4'b0010;
        do_txn(4'b0010, D1, 5, 4'd0, 4'd0, 1'b1);

        // Owner 3, with requester 0 raising during WAIT: wrap to 0.
        req = 4'b1000;
        do_txn(4'b1000, D3, 6, 4'd0, 4'b0001, 1'b0);
        do_txn(4'b0001, D0, 3, 4'd0, 4'd0, 1'b0);

        // Kill in WAIT aborts with all outputs cleared immediately.
        req = 4'b0100;
        wait_gnt(4'b0100, D2);
        req = 4'd0;
        repeat (3) @(negedge clk);
        #2 kill = 1'b1;
        #1;
        check("kill_gnt", gnt, 4'd0);
        check("kill_core_in_en", core_in_en, 1'b0);
        check("kill_core_data_in", core_data_in, 128'd0);
        check("kill_res_valid", res_valid, 4'd0);
        check("kill_res_data", res_data, 128'd0);
        check("kill_busy", busy, 1'b0);
        check("kill_core_kill", core_kill, 1'b0);
        check("kill_timeout_irq", timeout_irq_pulse, 1'b0);
        @(negedge clk);
        #2 kill = 1'b0;
        req = 4'b0010;
        do_txn(4'b0010, D1, 4, 4'd0, 4'd0, 1'b0);

        // Kill in IDLE, then all four held: order 0,1,2,3,0.
        @(negedge clk);
        #2 kill = 1'b1;
        @(negedge clk);
        #2 kill = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'(1 << (i % 4)), blk_tab[i % 4], 2 + i,
                   (i == 4) ? 4'd0 : 4'b1111, (i == 4) ? 4'd0 : 4'b1111, 1'b0);
        end

`ifdef AES_SCHED_TIMEOUT_EN
        // Core never answers: expiry after the 64th WAIT cycle.
        req = 4'b0001;
        wait_gnt(4'b0001, D0);
        req = 4'd0;
        repeat (64) @(negedge clk);
        check("wd_busy_c64", busy, 1'b1);
        check("wd_kill_c64", core_kill, 1'b0);
        @(negedge clk);
        check("wd_core_kill", core_kill, 1'b1);
        check("wd_irq", timeout_irq_pulse, 1'b1);
        check("wd_busy_after", busy, 1'b0);
        check("wd_res_valid", res_valid, 4'd0);
        @(negedge clk);
        check("wd_kill_pulse_end", core_kill, 1'b0);
        req = 4'b0010;
        do_txn(4'b0010, D1, 63, 4'd0, 4'd0, 1'b0);
        req = 4'b0100;
        do_txn(4'b0100, D2, 64, 4'd0, 4'd0, 1'b0);
`else
        // No watchdog: a 100-cycle core still completes normally.
        req = 4'b0001;
        do_txn(4'b0001, D0, 100, 4'd0, 4'd0, 1'b0);
        check("nowd_core_kill", core_kill, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1);
    end

endmodule

// File: doc/aes_128_sched.md
AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: kill  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: req  input  4  per-requester level request; bit i = requester i.
REQ-004 SHALL have port: req_data  input  512  plaintext blocks; bits [128*i+127:128*i] belong to requester i.
REQ-005 SHALL have port: gnt  output  4  one-hot, one-cycle pulse; request accepted and data latched.
REQ-006 SHALL have port: core_in_en  output  1  start pulse to the shared AES-128 core.
REQ-007 SHALL have port: core_data_in  output  128  block presented to the core; valid while core_in_en=1.
REQ-008 SHALL have port: core_out_en  input  1  core result-valid pulse.
REQ-009 SHALL have port: core_data_out  input  128  core ciphertext; valid while core_out_en=1.
REQ-010 SHALL have port: res_valid  output  4  one-hot, one-cycle pulse to the owning requester.
REQ-011 SHALL have port: res_data  output  128  ciphertext; valid while any res_valid bit=1.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: core_kill  output  1  one-cycle kill pulse to the core (timeout only).
REQ-014 SHALL have port: timeout_irq_pulse  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, DELIVER; one transition per clock at most.
REQ-016 IDLE: if req!=0, SHALL select winner by round-robin starting at ptr (2 bits), latch owner and req_data slice, go to ISSUE; else stay.
REQ-017 ISSUE: SHALL drive core_in_en=1, core_data_in=latched block, gnt[owner]=1 for exactly one cycle, then go to WAIT.
REQ-018 WAIT: on core_out_en=1 SHALL latch core_data_out into the result register and go to DELIVER; else stay.
REQ-019 DELIVER: SHALL drive res_valid[owner]=1 for one cycle with res_data=latched result, set ptr=owner+1 mod 4, go to IDLE.
REQ-020 Latency: req seen in IDLE at cycle N -> gnt and core_in_en at N+1; core_out_en at cycle M -> res_valid at M+1; minimum IDLE-to-IDLE turnaround is 4 cycles plus core latency.
REQ-021 core_out_en in IDLE, ISSUE or DELIVER SHALL be ignored, with no state change.
REQ-022 req changes outside IDLE SHALL be ignored; requesters SHALL drop req on gnt, and a req still high on return to IDLE is re-arbitrated as a new request.
REQ-023 Round-robin wrap: after owner 3, ptr=0; a sole requester SHALL be re-granted on every pass.
REQ-024 All outputs SHALL be registered; gnt, core_in_en and res_valid SHALL never be asserted simultaneously with another bit of the same vector.
REQ-025 res_data and core_data_in SHALL hold their last values when not valid.

Reset
REQ-026 kill=1 SHALL asynchronously force state=IDLE, ptr=0, owner=0, gnt=0, res_valid=0, core_in_en=0, core_kill=0, timeout_irq_pulse=0, busy=0, and clear data registers to 0.
REQ-027 kill asserted mid-operation SHALL abort the transaction with no res_valid pulse; the first arbitration after release starts at requester 0.

Configuration
REQ-028 Macro AES_SCHED_TIMEOUT_EN SHALL enable a 6-bit watchdog: cleared on entry to WAIT, incremented each WAIT cycle; at 63 without core_out_en -> core_kill=1 and timeout_irq_pulse=1 for one cycle, no res_valid, ptr=owner+1, state=IDLE.
REQ-029 If core_out_en and expiry coincide, core_out_en SHALL win (normal DELIVER, no timeout).
REQ-030 Without AES_SCHED_TIMEOUT_EN: no watchdog logic; core_kill and timeout_irq_pulse SHALL be constant 0, and WAIT is unbounded.

Verification
REQ-031 req=4'b0100, data2=X, core model returns X^K after 30 cycles -> gnt=4'b0100 one cycle after req, res_valid=4'b0100 with res_data=X^K one cycle after core_out_en.
REQ-032 req=4'b1111 held -> grant order 0,1,2,3,0; each requester receives exactly one res_valid per round.
REQ-033 req=4'b1000 then 4'b0001 issued during WAIT -> owner 3 completes, then owner 0 is granted (wrap-around ptr 0 after 3).
REQ-034 Spurious core_out_en in IDLE and ISSUE -> no state change and no res_valid.
REQ-035 kill pulse in WAIT -> all outputs 0 at once; next req=4'b0010 granted normally.
REQ-036 With AES_SCHED_TIMEOUT_EN and a core that never responds -> core_kill and timeout_irq_pulse asserted on the 64th WAIT cycle, busy=0 next cycle; out_en on cycle 63 -> normal delivery.
